d_cache_nway: RTL

- Parametrised N-way set-associative data cache between the pipeline MEM stage and the multi-cycle unified memory.
- Successor to the fixed 2-way write-through d_cache; adds configurable ways, sets and line length.
- Adds a write-back/write-allocate mode with dirty bits and victim writeback, true-LRU replacement, single-cycle hits and saturating hit/miss counters.

---
 rtl/d_cache_pkg.sv | 44 ++++
 rtl/d_cache_lru.sv | 61 ++++++
 rtl/d_cache_nway.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_pkg.sv
// Shared types and width helpers for the N-way data cache.
// Every address-field width is derived from the cache geometry here.
package d_cache_pkg;

    typedef enum logic [2:0] {
        COMPARE,
        WT_WRITE,
        WRITEBACK,
        FILL,
        REPLAY,
        DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // The byte offset covers the word select bits plus the ignored byte bit.
    function automatic int off_w(input int words);
        return clog2(words) + 1;
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int words);
        return 16 - off_w(words) - idx_w(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/d_cache_lru.sv
// True-LRU age tracking for every set: one age per way, and age WAYS-1 marks the oldest way.
// The victim is the lowest-index invalid way if there is one, otherwise the oldest way.
module d_cache_lru
    import d_cache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [idx_w(SETS)-1:0]  sel_idx,
    input  logic [WAYS-1:0]         sel_valid,
    output logic [way_w(WAYS)-1:0]  victim,
    input  logic                    upd_en,
    input  logic [idx_w(SETS)-1:0]  upd_idx,
    input  logic [way_w(WAYS)-1:0]  upd_way
);
    localparam int WW = way_w(WAYS);

    logic [WW-1:0] age_q [SETS][WAYS];
    logic [WW-1:0] row_d [WAYS];
    logic          found;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            row_d[w] = age_q[upd_idx][w];
            if (WW'(w) == upd_way)
                row_d[w] = '0;
            else if (age_q[upd_idx][w] < age_q[upd_idx][upd_way])
                row_d[w] = age_q[upd_idx][w] + 1'b1;
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!sel_valid[w] && !found) begin
                victim = WW'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[sel_idx][w] == WW'(WAYS - 1)) victim = WW'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    age_q[s][w] <= WW'(w);
        end else if (upd_en) begin
            for (int w = 0; w < WAYS; w++)
                age_q[upd_idx][w] <= row_d[w];
        end
    end

endmodule

// File: rtl/d_cache_nway.sv
// N-way set-associative data cache between the MEM stage and the unified multi-cycle memory.
// It supports write-back/write-allocate or write-through/no-allocate operation, with single-cycle hits.
module d_cache_nway
    import d_cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int WORDS      = 8,
    parameter int WRITE_BACK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [15:0] memory_address,
    output logic [15:0] memory_wdata,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int            OW      = off_w(WORDS);
    localparam int            IW      = idx_w(SETS);
    localparam int            TW      = tag_w(SETS, WORDS);
    localparam int            WW      = way_w(WAYS);
    localparam int            CW      = clog2(WORDS);
    localparam bit            WB      = (WRITE_BACK != 0);
    localparam logic [CW:0]   CNT_END = (CW+1)'(WORDS);
    localparam logic [CW-1:0] LAST    = CW'(WORDS - 1);

    logic [15:0]     data_q  [WAYS][SETS][WORDS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [SETS-1:0] valid_q [WAYS];
    logic [SETS-1:0] dirty_q [WAYS];

    state_e        state_q, state_d;
    logic [15:0]   req_addr_q, req_addr_d, req_data_q, req_data_d;
    logic [15:0]   rdata_q, rdata_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic          req_wr_q, req_wr_d;
    logic [WW-1:0] victim_q, victim_d;
    logic [CW:0]   cnt_q, cnt_d;
    logic [CW-1:0] rcv_q, rcv_d;

    logic          req, hit, victim_dirty;
    logic [TW-1:0] a_tag, l_tag;
    logic [IW-1:0] a_idx, l_idx;
    logic [CW-1:0] a_word, l_word;
    logic [WAYS-1:0] hit_vec, set_valid;
    logic [WW-1:0] hit_way, lru_victim;

    logic          data_we, meta_we, dirty_set, lru_upd;
    logic [WW-1:0] wr_way;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_word;
    logic [15:0]   wr_data;
    logic          unused_bits;

    // Requests are masked while reset is held, so every output reads zero during reset.
    assign req    = enable & ~rst_n;
    assign a_tag  = addr[15 -: TW];
    assign a_idx  = addr[OW +: IW];
    assign a_word = addr[1 +: CW];
    assign l_tag  = req_addr_q[15 -: TW];
    assign l_idx  = req_addr_q[OW +: IW];
    assign l_word = req_addr_q[1 +: CW];
    assign unused_bits = ^{addr[0], req_addr_q[0]};

    always_comb begin
        hit_vec   = '0;
        set_valid = '0;
        hit_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][a_idx];
            hit_vec[w]   = valid_q[w][a_idx] && (tag_q[w][a_idx] == a_tag);
            if (hit_vec[w]) hit_way = WW'(w);
        end
    end

    assign hit          = |hit_vec;
    assign victim_dirty = set_valid[lru_victim] & dirty_q[lru_victim][a_idx];
    assign lru_upd      = ((state_q == COMPARE) && req && hit) || meta_we;

    d_cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk       (clk),
        .rst       (rst_n),
        .sel_idx   (a_idx),
        .sel_valid (set_valid),
        .victim    (lru_victim),
        .upd_en    (lru_upd),
        .upd_idx   (wr_idx),
        .upd_way   (wr_way)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            COMPARE: begin
                if (req) begin
                    if (wr && !WB)
                        state_d = WT_WRITE;
                    else if (!hit)
                        state_d = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WT_WRITE:  state_d = DONE;
            WRITEBACK: if (cnt_q[CW-1:0] == LAST) state_d = FILL;
            FILL:      if (memory_data_valid && rcv_q == LAST) state_d = REPLAY;
            REPLAY:    state_d = DONE;
            DONE:      state_d = COMPARE;
            default:   state_d = COMPARE;
        endcase
    end

    // A single array write port serves COMPARE hits, FILL returns and REPLAY stores, since these never overlap.
    always_comb begin
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_wr_d   = req_wr_q;
        victim_d   = victim_q;
        cnt_d      = cnt_q;
        rcv_d      = rcv_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_we    = 1'b0;
        meta_we    = 1'b0;
        dirty_set  = 1'b0;
        wr_way     = hit_way;
        wr_idx     = a_idx;
        wr_word    = a_word;
        wr_data    = data_in;
        case (state_q)
            COMPARE: begin
                req_addr_d = addr;
                req_data_d = data_in;
                req_wr_d   = wr;
                victim_d   = lru_victim;
                cnt_d      = '0;
                rcv_d      = '0;
                if (req) begin
                    rdata_d = data_in;
                    if (hit) begin
                        hit_cnt_d = sat_inc16(hit_cnt_q);
                        data_we   = wr;
                        dirty_set = wr & WB;
                    end else begin
                        miss_cnt_d = sat_inc16(miss_cnt_q);
                    end
                end
            end
            WRITEBACK: cnt_d = (cnt_q[CW-1:0] == LAST) ? '0 : cnt_q + 1'b1;
            FILL: begin
                wr_way  = victim_q;
                wr_idx  = l_idx;
                wr_word = rcv_q;
                wr_data = memory_data;
                if (cnt_q != CNT_END) cnt_d = cnt_q + 1'b1;
                if (memory_data_valid) begin
                    data_we = 1'b1;
                    rcv_d   = rcv_q + 1'b1;
                    meta_we = (rcv_q == LAST);
                end
            end
            REPLAY: begin
                wr_way    = victim_q;
                wr_idx    = l_idx;
                wr_word   = l_word;
                wr_data   = req_data_q;
                data_we   = req_wr_q;
                dirty_set = req_wr_q & WB;
                if (!req_wr_q) rdata_d = data_q[victim_q][l_idx][l_word];
            end
            default: ;
        endcase
    end

    always_comb begin
        stall          = 1'b0;
        mem_enable     = 1'b0;
        mem_write      = 1'b0;
        memory_address = '0;
        memory_wdata   = '0;
        data_out       = '0;
        case (state_q)
            COMPARE: begin
                if (req) begin
                    stall = !(hit && (!wr || WB));
                    if (hit && !wr) data_out = data_q[hit_way][a_idx][a_word];
                end
            end
            WT_WRITE: begin
                stall          = 1'b1;
                mem_write      = 1'b1;
                memory_address = {req_addr_q[15:1], 1'b0};
                memory_wdata   = req_data_q;
            end
            WRITEBACK: begin
                stall          = 1'b1;
                mem_write      = 1'b1;
                memory_address = {tag_q[victim_q][l_idx], l_idx, cnt_q[CW-1:0], 1'b0};
                memory_wdata   = data_q[victim_q][l_idx][cnt_q[CW-1:0]];
            end
            FILL: begin
                stall = 1'b1;
                if (cnt_q != CNT_END) begin
                    mem_enable     = 1'b1;
                    memory_address = {l_tag, l_idx, cnt_q[CW-1:0], 1'b0};
                end
            end
            REPLAY:  stall = 1'b1;
            DONE:    data_out = rdata_q;
            default: ;
        endcase
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= COMPARE;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_wr_q   <= 1'b0;
            victim_q   <= '0;
            cnt_q      <= '0;
            rcv_q      <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_wr_q   <= req_wr_d;
            victim_q   <= victim_d;
            cnt_q      <= cnt_d;
            rcv_q      <= rcv_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[wr_way][wr_idx][wr_word] <= wr_data;
        if (meta_we) tag_q[wr_way][wr_idx] <= l_tag;
    end

    // The valid bit is set only when the last word lands, so an aborted fill leaves the line invalid.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            if (meta_we) begin
                valid_q[wr_way][wr_idx] <= 1'b1;
                dirty_q[wr_way][wr_idx] <= 1'b0;
            end
            if (dirty_set) dirty_q[wr_way][wr_idx] <= 1'b1;
        end
    end

endmodule
